// File: rtl/dmem_checker_pkg.sv
// Shared status encodings, widths and small helpers for the data-memory checker.
package dmem_checker_pkg;

  // Checker verdict; RUN is the only non-terminal state.
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_t;

  localparam int          DATA_W    = 32;
  localparam int          WRCNT_W   = 16;
  localparam logic [15:0] WRCNT_MAX = 16'hFFFF;

  // Saturating increment for the store counter.
  function automatic logic [WRCNT_W-1:0] sat_inc16(input logic [WRCNT_W-1:0] v);
    if (v == WRCNT_MAX) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // A byte address is word aligned when its two low bits are zero.
  function automatic logic is_aligned(input logic [DATA_W-1:0] a);
    return (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed data RAM: asynchronous read, synchronous write with enable.
// Contents are never cleared; the owner decides when writes are allowed.
module dmem_ram #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Store the write data into the indexed word when enabled.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_checker.sv
// Data-memory model with a store checker: watches processor stores, keeps
// a RAM image and latches a sticky PASS / FAIL / TIMEOUT verdict.
module dmem_checker
  import dmem_checker_pkg::*;
#(
  parameter int          DEPTH      = 64,
  parameter logic [31:0] EXP_ADDR   = 32'd84,
  parameter logic [31:0] EXP_DATA   = 32'd7,
  parameter logic [31:0] ALLOW_ADDR = 32'd80,
  parameter int          TIMEOUT    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  status,
  output logic        done,
  output logic [15:0] wr_count,
  output logic [31:0] fail_addr,
  output logic [31:0] fail_data
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);
  // The timeout fires on the edge where the counter already holds TIMEOUT-1.
  localparam logic [31:0] CYC_LAST  = 32'(TIMEOUT - 1);

  status_t         r_state;
  status_t         w_state_nxt;
  logic            r_done;
  logic [31:0]     r_cycle;
  logic [15:0]     r_wr_count;
  logic [31:0]     r_fail_addr;
  logic [31:0]     r_fail_data;

  logic [AW-1:0]   w_ram_idx;
  logic            w_ram_we;
  logic            w_store_pass;
  logic            w_store_fail;
  logic            w_capture;
  logic            w_in_run;

  // RAM index comes straight from the word bits of the byte address; writes
  // happen in every verdict state but never during reset or out of range.
  assign w_ram_idx = dataadr[AW+1:2];
  assign w_ram_we  = memwrite & ~reset & (dataadr < RAM_BYTES);
  assign w_in_run  = (r_state == ST_RUN);

  dmem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_idx   (w_ram_idx),
    .i_wdata (writedata),
    .o_rdata (readdata)
  );

  // Classify the current store: the expected result write passes, the
  // tolerated address is neutral, anything else is a failure.
  always_comb begin
    w_store_pass = 1'b0;
    w_store_fail = 1'b0;
    if (!memwrite) begin
      w_store_pass = 1'b0;
      w_store_fail = 1'b0;
    end else if (!is_aligned(dataadr)) begin
      w_store_fail = 1'b1;
    end else if (dataadr == EXP_ADDR) begin
      if (writedata == EXP_DATA) begin
        w_store_pass = 1'b1;
      end else begin
        w_store_fail = 1'b1;
      end
    end else if (dataadr == ALLOW_ADDR) begin
      w_store_pass = 1'b0;
      w_store_fail = 1'b0;
    end else begin
      w_store_fail = 1'b1;
    end
  end

  // Next verdict: a deciding store outranks the timeout; terminal states hold.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_store_fail) begin
          w_state_nxt = ST_FAIL;
          w_capture   = 1'b1;
        end else if (w_store_pass) begin
          w_state_nxt = ST_PASS;
        end else if (r_cycle == CYC_LAST) begin
          w_state_nxt = ST_TIMEOUT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        w_state_nxt = r_state;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Verdict state register and the registered done flag derived from it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt != ST_RUN);
    end
  end

  // RUN-cycle counter feeding the timeout decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle <= 32'd0;
    end else if (w_in_run) begin
      r_cycle <= r_cycle + 32'd1;
    end else begin
      r_cycle <= r_cycle;
    end
  end

  // Count every store seen while running, the deciding one included.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_count <= 16'd0;
    end else if (w_in_run && memwrite) begin
      r_wr_count <= sat_inc16(r_wr_count);
    end else begin
      r_wr_count <= r_wr_count;
    end
  end

  // Capture the address and data of the store that caused FAIL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fail_addr <= 32'd0;
      r_fail_data <= 32'd0;
    end else if (w_capture) begin
      r_fail_addr <= dataadr;
      r_fail_data <= writedata;
    end else begin
      r_fail_addr <= r_fail_addr;
      r_fail_data <= r_fail_data;
    end
  end

  assign status    = r_state;
  assign done      = r_done;
  assign wr_count  = r_wr_count;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;

endmodule

// File: tb/tb_dmem_checker.sv
// Self-checking bench: two checker instances with different parameters share
// one stimulus stream and are compared against a rule-level reference model.
module tb_dmem_checker;

  localparam int          TO_A    = 40;
  localparam int          TO_B    = 10;
  localparam logic [31:0] ALLOW_A = 32'd80;
  localparam logic [31:0] ALLOW_B = 32'd256;
  localparam logic [31:0] EXP_A   = 32'd84;
  localparam logic [31:0] EXP_D   = 32'd7;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;

  logic [31:0] rd_a, fa_a, fd_a, rd_b, fa_b, fd_b;
  logic [1:0]  st_a, st_b;
  logic        done_a, done_b;
  logic [15:0] wr_a, wr_b;

  int n_checks;
  int n_fail;

  // reference model state, index 0 = instance A, 1 = instance B
  logic [1:0]  m_st  [2];
  int          m_wr  [2];
  int          m_cyc [2];
  logic [31:0] m_fa  [2];
  logic [31:0] m_fd  [2];
  logic [31:0] m_mem [64];
  bit          m_val [64];

  dmem_checker #(.DEPTH(64), .EXP_ADDR(EXP_A), .EXP_DATA(EXP_D),
                 .ALLOW_ADDR(ALLOW_A), .TIMEOUT(TO_A)) u_dut_a (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(rd_a), .status(st_a), .done(done_a),
    .wr_count(wr_a), .fail_addr(fa_a), .fail_data(fd_a));

  dmem_checker #(.DEPTH(64), .EXP_ADDR(EXP_A), .EXP_DATA(EXP_D),
                 .ALLOW_ADDR(ALLOW_B), .TIMEOUT(TO_B)) u_dut_b (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(rd_b), .status(st_b), .done(done_b),
    .wr_count(wr_b), .fail_addr(fa_b), .fail_data(fd_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Apply the checker rules for one rising edge to one instance's model.
  task automatic model_edge(input int k, input logic rst, input logic we,
                            input logic [31:0] adr, input logic [31:0] wd);
    int          to;
    logic [31:0] allow;
    bit          decided;
    to      = (k == 0) ? TO_A : TO_B;
    allow   = (k == 0) ? ALLOW_A : ALLOW_B;
    decided = 1'b0;
    if (rst) begin
      m_st[k] = 2'b00; m_wr[k] = 0; m_cyc[k] = 0; m_fa[k] = 32'd0; m_fd[k] = 32'd0;
      return;
    end
    if (m_st[k] != 2'b00) return;
    if (we) begin
      m_wr[k] = (m_wr[k] < 65535) ? m_wr[k] + 1 : 65535;
      if ((adr % 32'd4) != 32'd0 || (adr != EXP_A && adr != allow) ||
          (adr == EXP_A && wd != EXP_D)) begin
        m_st[k] = 2'b10; m_fa[k] = adr; m_fd[k] = wd; decided = 1'b1;
      end else if (adr == EXP_A) begin
        m_st[k] = 2'b01; decided = 1'b1;
      end
    end
    if (!decided && m_cyc[k] == to - 1) m_st[k] = 2'b11;
    m_cyc[k]++;
  endtask

  // One clock: drive on falling edge, update model at rising edge, compare 1ns later.
  task automatic step(input logic rst, input logic we,
                      input logic [31:0] adr, input logic [31:0] wd);
    int idx;
    @(negedge clk);
    reset = rst; memwrite = we; dataadr = adr; writedata = wd;
    @(posedge clk);
    model_edge(0, rst, we, adr, wd);
    model_edge(1, rst, we, adr, wd);
    if (!rst && we && adr < 32'd256) begin
      m_mem[adr / 32'd4] = wd;
      m_val[adr / 32'd4] = 1'b1;
    end
    #1;
    idx = int'(adr[7:2]);
    chk("status_a", 32'(st_a), 32'(m_st[0]));
    chk("status_b", 32'(st_b), 32'(m_st[1]));
    chk("done_a", 32'(done_a), 32'(m_st[0] != 2'b00));
    chk("done_b", 32'(done_b), 32'(m_st[1] != 2'b00));
    chk("wr_count_a", 32'(wr_a), 32'(m_wr[0]));
    chk("wr_count_b", 32'(wr_b), 32'(m_wr[1]));
    chk("fail_addr_a", fa_a, m_fa[0]);
    chk("fail_data_a", fd_a, m_fd[0]);
    chk("fail_addr_b", fa_b, m_fa[1]);
    chk("fail_data_b", fd_b, m_fd[1]);
    if (m_val[idx]) begin
      chk("readdata_a", rd_a, m_mem[idx]);
      chk("readdata_b", rd_b, m_mem[idx]);
    end
  endtask

  initial begin
    logic [31:0] old0;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rst;
    logic        we;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; memwrite = 1'b0; dataadr = 32'd0; writedata = 32'd0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 2'b00; m_wr[i] = 0; m_cyc[i] = 0; m_fa[i] = 32'd0; m_fd[i] = 32'd0;
    end
    for (int i = 0; i < 64; i++) begin
      m_mem[i] = 32'd0; m_val[i] = 1'b0;
    end

    // reset state, then fill the whole RAM (first store fails, later ones still write)
    step(1'b1, 1'b0, 32'd0, 32'd0);
    chk("reset_status", 32'(st_a), 32'd0);
    chk("reset_wr", 32'(wr_a), 32'd0);
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 32'(i * 4), $urandom);

    // allowed store then expected result
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 32'd80, 32'd3);
    chk("allow_run", 32'(st_a), 32'd0);
    step(1'b0, 1'b1, 32'd84, 32'd7);
    chk("pass_status", 32'(st_a), 32'd1);
    chk("pass_wr", 32'(wr_a), 32'd2);
    step(1'b0, 1'b0, 32'd84, 32'd0);
    chk("pass_rd84", rd_a, 32'd7);

    // wrong data at the result address, then a later correct store
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 32'd84, 32'd6);
    chk("bad_status", 32'(st_a), 32'd2);
    chk("bad_faddr", fa_a, 32'd84);
    chk("bad_fdata", fd_a, 32'd6);
    step(1'b0, 1'b1, 32'd84, 32'd7);
    chk("sticky_fail", 32'(st_a), 32'd2);
    chk("word21", rd_a, 32'd7);

    // stray address, misaligned address
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 32'd44, 32'd1);
    chk("stray_faddr", fa_a, 32'd44);
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 32'd82, 32'd1);
    chk("misal_status", 32'(st_a), 32'd2);
    chk("misal_faddr", fa_a, 32'd82);

    // timeout on instance B after exactly 10 RUN edges
    step(1'b1, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    chk("to_edge9", 32'(st_b), 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0);
    chk("to_edge10", 32'(st_b), 32'd3);
    // deciding store on the 10th edge beats the timeout
    step(1'b1, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 32'd84, 32'd7);
    chk("to_store_wins", 32'(st_b), 32'd1);

    // reset while in PASS with a concurrent store to word 0
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 32'd84, 32'd7);
    old0 = m_mem[0];
    step(1'b1, 1'b1, 32'd0, ~old0);
    chk("rst_pass_status", 32'(st_a), 32'd0);
    chk("rst_pass_wr", 32'(wr_a), 32'd0);
    chk("rst_ram_kept", rd_a, old0);

    // out-of-range store to the tolerated address on instance B
    step(1'b1, 1'b0, 32'd0, 32'd0);
    old0 = m_mem[0];
    step(1'b0, 1'b1, 32'd256, 32'hDEAD_BEEF);
    chk("oor_status", 32'(st_b), 32'd0);
    chk("oor_wr", 32'(wr_b), 32'd1);
    chk("oor_ram", rd_b, old0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) < 3);
      we  = ($urandom_range(0, 99) < 15);
      case ($urandom_range(0, 7))
        0:       adr = 32'd84;
        1:       adr = 32'd80;
        2:       adr = 32'd256;
        3:       adr = 32'($urandom_range(0, 63)) * 32'd4;
        4:       adr = 32'($urandom_range(0, 255));
        5:       adr = 32'd0;
        6:       adr = $urandom;
        default: adr = 32'd84;
      endcase
      wd = ($urandom_range(0, 1) == 1) ? 32'd7 : 32'($urandom_range(0, 15));
      step(rst, we, adr, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_checker.md
DMEM_CHECKER -- requirements
Module: dmem_checker

Interface
REQ-001 Parameter DEPTH, 64, number of 32-bit RAM words (power of 2).
REQ-002 Parameter EXP_ADDR, 84, byte address of the terminal result write.
REQ-003 Parameter EXP_DATA, 7, required data for the terminal result write.
REQ-004 Parameter ALLOW_ADDR, 80, byte address of a tolerated intermediate write.
REQ-005 Parameter TIMEOUT, 1000, RUN cycles before the TIMEOUT verdict.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 memwrite  input  1  processor store strobe, sampled on rising clk.
REQ-009 dataadr  input  32  processor byte address.
REQ-010 writedata  input  32  processor store data.
REQ-011 readdata  output  32  RAM word at dataadr, combinational read.
REQ-012 status  output  2  verdict: 00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT.
REQ-013 done  output  1  high when status != RUN.
REQ-014 wr_count  output  16  number of stores accepted in RUN.
REQ-015 fail_addr  output  32  dataadr of the store that caused FAIL.
REQ-016 fail_data  output  32  writedata of the store that caused FAIL.

Function
REQ-017 RAM index SHALL be dataadr[log2(DEPTH)+1:2]; readdata SHALL reflect that word in the same cycle as dataadr.
REQ-018 On a rising edge with memwrite=1, reset=0 and dataadr < 4*DEPTH, the RAM SHALL store writedata at the indexed word; a store with dataadr >= 4*DEPTH SHALL leave the RAM unchanged.
REQ-019 A store SHALL update the RAM in every status state; only the checker state is sticky.
REQ-020 FSM states: RUN, PASS, FAIL, TIMEOUT; PASS, FAIL and TIMEOUT SHALL be terminal until reset.
REQ-021 In RUN, a store with dataadr==EXP_ADDR and writedata==EXP_DATA SHALL move to PASS at that edge.
REQ-022 In RUN, a store with dataadr[1:0]!=0, or with dataadr differing from both EXP_ADDR and ALLOW_ADDR, or with dataadr==EXP_ADDR and writedata!=EXP_DATA, SHALL move to FAIL and capture fail_addr/fail_data at that edge.
REQ-023 In RUN, a store with dataadr==ALLOW_ADDR SHALL stay in RUN.
REQ-024 A cycle counter SHALL increment on every RUN edge; when it reaches TIMEOUT-1 with no deciding store, the FSM SHALL move to TIMEOUT.
REQ-025 When a deciding store and timeout coincide, the store verdict SHALL take priority over TIMEOUT.
REQ-026 wr_count SHALL increment on each store sampled in RUN, including the deciding store, and saturate at 16'hFFFF.
REQ-027 Outputs status, done, wr_count, fail_* SHALL be registered; a verdict becomes visible one edge after the store cycle begins, i.e. immediately after the sampling edge.
REQ-028 Stores in terminal states SHALL NOT change status, wr_count or fail_*.

Reset
REQ-029 With reset=1 at a rising edge: status=RUN, done=0, wr_count=0, cycle counter=0, fail_addr=0, fail_data=0.
REQ-030 RAM writes SHALL be suppressed while reset=1; RAM contents SHALL NOT be cleared by reset.
REQ-031 Reset asserted in any state, including mid-RUN or terminal, SHALL return to RUN at that edge with counters cleared.

Structure
REQ-032 Package dmem_checker_pkg SHALL hold the status encodings (ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT) and the 2-bit status type.
REQ-033 The RAM SHALL be a sub-module dmem_ram (DEPTH x 32, async read, sync write with write-enable); FSM and counters stay in dmem_checker.

Verification
REQ-034 Reset for 2 cycles, store 80<-3 then 84<-7 -> status 00 after the first store, 01 after the second, wr_count=2, readdata at 84 = 7.
REQ-035 Store 84<-6 -> status 10, fail_addr=84, fail_data=6; a subsequent 84<-7 leaves status 10 but RAM word 21 = 7.
REQ-036 Store 44<-1 -> FAIL with fail_addr=44; store 82<-1 (misaligned) after reset -> FAIL with fail_addr=82.
REQ-037 TIMEOUT=10, no stores -> status 11 after exactly 10 RUN edges; with 84<-7 on the 10th edge -> status 01.
REQ-038 Assert reset while in PASS and while memwrite=1 to address 0 -> status 00, wr_count 0, RAM word 0 unchanged.
REQ-039 Store to 256 (>= 4*DEPTH) with ALLOW_ADDR=256 -> RAM unchanged, status stays 00, wr_count increments.
